// File: rtl/pmem_arbiter.sv
// pmem_arbiter: multiplexes NUM_CH cache-line requesters onto one physical-memory port
module pmem_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int ARB_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic [LINE_W-1:0]          pmem_wdata,
  input  logic                       pmem_resp,
  input  logic [LINE_W-1:0]          pmem_rdata
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  state_e              state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d, last_q, last_d, win, idx;
  logic                rd_q, rd_d, wr_q, wr_d, found;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_CH-1:0]   resp_q, resp_d, req;
  // Round-robin starts the search just after the last served channel
  always_comb begin
    req = ch_read | ch_write;
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (ARB_MODE != 0) ? IW'((int'(last_q) + k + 1) % NUM_CH) : IW'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = BUSY;
        grant_d = win;
        wr_d    = ch_write[win];
        rd_d    = !ch_write[win];
        addr_d  = ch_address[win*ADDR_W +: ADDR_W];
        wdata_d = ch_wdata[win*LINE_W +: LINE_W];
      end
      BUSY: if (pmem_resp) begin
        state_d = RESP;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        rdata_d = rd_q ? pmem_rdata : rdata_q;
        resp_d  = NUM_CH'(1) << grant_q;
      end
      RESP: begin
        state_d = IDLE;
        resp_d  = '0;
        last_d  = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_CH - 1);
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end
  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign ch_rdata     = rdata_q;
  assign ch_resp      = resp_q;
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Parametrised arbiter that multiplexes NUM_CH cache-line requesters onto a single physical-memory port.
- Requesters are the I-cache, the D-cache and optional victim/prefetch buffers.
- Successor to the two-port split instruction/data memory interface, generalised in channel count, line width, address width and arbitration mode.
- Sits between the cache layer and pmem in the top-level mp3 hierarchy.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8); channel 0 is the I-cache by convention.
- ADDR_W, 16, byte address width.
- LINE_W, 128, cache line width in bits.
- ARB_MODE, 1, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ch_read  in  NUM_CH  per-channel line-read request (level, held until ch_resp).
- ch_write  in  NUM_CH  per-channel line-write request (level, held until ch_resp).
- ch_address  in  NUM_CH*ADDR_W  per-channel address, channel i in bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*LINE_W  per-channel write line, channel i in bits [i*LINE_W +: LINE_W].
- ch_rdata  out  LINE_W  read line, broadcast to all channels, valid when ch_resp is high.
- ch_resp  out  NUM_CH  one-cycle completion pulse for the served channel.
- pmem_read  out  1  physical-memory read strobe.
- pmem_write  out  1  physical-memory write strobe.
- pmem_address  out  ADDR_W  physical-memory address.
- pmem_wdata  out  LINE_W  physical-memory write line.
- pmem_resp  in  1  physical-memory completion.
- pmem_rdata  in  LINE_W  physical-memory read line.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs clear immediately.
  - pmem_read, pmem_write = 0; pmem_address, pmem_wdata = 0; ch_resp = 0; ch_rdata = 0.
  - FSM goes to IDLE; round-robin pointer last_grant = NUM_CH-1, so channel 0 has first priority.
- Reset mid-transaction: the transaction is abandoned and no ch_resp is issued. pmem must tolerate strobe removal.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - A channel is requesting when ch_read[i] | ch_write[i].
  - If any channel is requesting, the edge selects a winner g.
  - On the same edge: latch g, its address and wdata, and op = write if ch_write[g] else read. Both strobes high counts as a write.
  - Drive the registered pmem_read/pmem_write, pmem_address and pmem_wdata; go to BUSY.
  - No request: stay in IDLE, strobes remain 0.
- BUSY:
  - Hold the strobe, address and wdata stable from registers.
  - Changes on the ch_* inputs are ignored, including the requester dropping its request.
  - On the edge where pmem_resp=1: clear both strobes, register pmem_rdata into ch_rdata, set ch_resp[g]=1 and go to RESP.
- RESP:
  - ch_resp[g] is high for exactly this one cycle; new requests are not sampled.
  - Next edge: ch_resp = 0, last_grant = g, go to IDLE.
  - ch_rdata holds its value until the next read completes.
- Arbitration:
  - ARB_MODE=0: the lowest requesting index wins.
  - ARB_MODE=1: search indices last_grant+1 .. NUM_CH-1, then wrap to 0 .. last_grant; first requester wins.
  - Wrap-around: index NUM_CH-1 is followed by 0.
  - A lone requester is granted back-to-back regardless of mode.
- Latency:
  - Request sampled in IDLE to pmem strobe: 1 edge.
  - pmem_resp to ch_resp: 1 edge.
  - Minimum per-transaction occupancy: 3 cycles plus pmem latency.
  - Minimum gap between consecutive grants: 1 IDLE cycle.
- Don't-care and illegal inputs:
  - pmem_resp asserted in IDLE or RESP is ignored.
  - ch_rdata is don't-care after a write completion, but must not change on a write.
- Only one pmem transaction is outstanding at any time; no reordering is performed.

Test Plan:
- Single read: ch_read=2'b01, addr0=16'h0040. Required response:
  - pmem_read=1 with pmem_address=16'h0040 one edge later.
  - pmem_resp with pmem_rdata=128'hDEAD...BEEF gives ch_resp=2'b01 for one cycle with ch_rdata equal to that line.
- Write on channel 1: ch_write[1]=1, addr1=16'h1230, wdata1=128'h0123...CDEF. Required response:
  - pmem_write=1 with the same address and data, pmem_read=0.
  - ch_resp=2'b10 for one cycle after pmem_resp.
- Round-robin contention (ARB_MODE=1, NUM_CH=4): all four channels read continuously and deassert only on their own ch_resp.
  - Grant order must be 0,1,2,3,0.
  - No channel is served twice before all others have been served.
- Fixed priority (ARB_MODE=0): channels 0 and 1 both request and channel 0 re-requests immediately after completion.
  - Channel 0 is served twice in a row; channel 1 waits.
- Stability: vary addr0 and drop ch_read[0] while in BUSY with pmem latency 5 cycles.
  - pmem_address stays at the latched value and ch_resp[0] still pulses.
- Async reset: assert rst_n=0 mid-BUSY with no clock edge.
  - pmem_read drops combinationally and no ch_resp appears.
  - After release, channel 0 is granted first.
